unit_test_run_ctrl: RTL and testbench
=====================================

Name: unit_test_run_ctrl

Overview:
Hardware test-run sequencer for synthesizable self-checking benches. It launches up to NUM_TESTS test slots one at a time, waits for each to finish (pass/fail) or time out, and tallies results. Each result is handed to a logger sink through a valid/ready handshake. It sits between a bench top-level and the per-slot test engines and mirrors the run-and-log flow of the unit-test framework.

Parameters:
NUM_TESTS, 8, number of test slots; legal range 1..256
TIMEOUT_W, 16, width of the watchdog limit and counter
CNT_W, 8, width of each result counter; counters saturate

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
run_i  in  1  pulse that starts a run; ignored while busy_o=1
enable_mask_i  in  NUM_TESTS  bit i=1 runs slot i; sampled on the run_i cycle
timeout_i  in  TIMEOUT_W  watchdog limit in cycles; sampled on the run_i cycle; 0 disables the watchdog
test_start_o  out  1  one-cycle start pulse to the selected slot
test_id_o  out  ID_W  current slot index; ID_W = max(1,$clog2(NUM_TESTS))
test_done_i  in  1  slot finished; qualified only in WAIT
test_pass_i  in  1  pass/fail, sampled with test_done_i
log_valid_o  out  1  result record valid
log_ready_i  in  1  logger accepts the record
log_id_o  out  ID_W  slot index of the record
log_result_o  out  2  0=PASS 1=FAIL 2=TIMEOUT 3=SKIP
busy_o  out  1  run in progress
run_done_o  out  1  one-cycle pulse when the run completes
pass_cnt_o, fail_cnt_o, timeout_cnt_o, skip_cnt_o  out  CNT_W each  result tallies

Behaviour:
- Reset: all outputs 0, state IDLE, latched mask 0, counters 0.
- States and transitions:
  - IDLE: run_i -> latch mask and timeout, clear counters, idx=0, go to SELECT.
  - SELECT: if mask[idx]=0 -> record SKIP, go to LOG. Otherwise go to START.
  - START: test_start_o=1 for exactly one cycle, watchdog cleared to 0, go to WAIT.
  - WAIT: watchdog increments each cycle. test_done_i -> result PASS or FAIL per test_pass_i. Else if timeout≠0 and watchdog==timeout-1 -> TIMEOUT. Done has priority when both occur in the same cycle. Either outcome goes to LOG.
  - LOG: log_valid_o=1 with log_id_o/log_result_o held stable until log_ready_i. On accept, increment the matching counter (saturating at 2^CNT_W-1). Then if idx==NUM_TESTS-1 go to DONE, else idx+1 and go to SELECT.
  - DONE: run_done_o=1 for one cycle, busy_o drops, go to IDLE.
- busy_o=1 in every state except IDLE.
- test_id_o tracks idx in all states and holds its last value in IDLE.
- Latency for an enabled slot: start pulse 2 cycles after run_i, at the earliest.
- Latency for a skipped slot: 2 cycles per slot with log_ready_i tied high.
- test_done_i outside WAIT is ignored.
- run_i during a run is ignored and is not queued.
- log_valid_o never drops before acceptance.
- rst_n assertion mid-run aborts immediately to the reset state; no run_done_o pulse.
- Counters hold their values after a run until the next run_i.

Optional Feature:
UNIT_TEST_STOP_ON_FAIL_EN
- Defined: after a FAIL or TIMEOUT record is accepted in LOG, every remaining slot is logged as SKIP (without start pulses) and the run then completes normally.
- Not defined: all slots run regardless of earlier failures.

Decomposition:
- Package unit_test_run_pkg holds:
  - result_e enum (PASS, FAIL, TIMEOUT, SKIP; 2 bits)
  - state_e enum (IDLE, SELECT, START, WAIT, LOG, DONE)
  - function sat_inc(cnt) for saturating counter increment
- Sub-module unit_test_watchdog: TIMEOUT_W counter with clear, enable and limit; outputs an expired flag. The natural split.

Test Plan:
- NUM_TESTS=4, mask=4'b1111, timeout=100, each slot returns done+pass 5 cycles after start -> four PASS records with ids 0..3, pass_cnt=4, one run_done_o pulse.
- mask=4'b0101 -> slots 1 and 3 logged SKIP with no start pulse; skip_cnt=2, pass_cnt=2.
- timeout=10, slot 2 never signals done -> TIMEOUT record for id 2, timeout_cnt=1, run continues to slot 3.
- log_ready_i low for 7 cycles on a FAIL record -> log_valid_o, log_id_o and log_result_o held stable; fail_cnt increments only on the acceptance cycle.
- test_done_i on the exact cycle the watchdog expires -> PASS/FAIL recorded, timeout_cnt unchanged. Assert rst_n low during WAIT -> all outputs 0 next edge, no run_done_o.
- With UNIT_TEST_STOP_ON_FAIL_EN and slot 1 failing (mask all ones) -> slots 2..3 logged SKIP with no start pulses; fail_cnt=1, skip_cnt=2.

Source files
------------

// File: rtl/unit_test_run_pkg.sv
// Shared types and helpers for the unit-test run sequencer.
package unit_test_run_pkg;

    // Result code carried on log_result_o.
    typedef enum logic [1:0] {
        RES_PASS    = 2'd0,
        RES_FAIL    = 2'd1,
        RES_TIMEOUT = 2'd2,
        RES_SKIP    = 2'd3
    } result_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOG    = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Saturating increment; callers cast back to their own counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
        return (cnt >= max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/unit_test_run_ctrl_watchdog.sv
// Per-test watchdog: counts WAIT cycles and flags the last cycle before the limit.
module unit_test_watchdog
    import unit_test_run_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 expired_c
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Clear has priority over counting; a zero limit never expires.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (limit_i != '0) && (cnt_q == (limit_i - TIMEOUT_W'(1)));

endmodule

// File: rtl/unit_test_run_ctrl.sv
// Test-run sequencer: launches enabled slots in order, logs one record per slot,
// and tallies results. Optional macro UNIT_TEST_STOP_ON_FAIL_EN turns every slot
// after the first accepted FAIL/TIMEOUT into a SKIP.
module unit_test_run_ctrl
    import unit_test_run_pkg::*;
#(
    parameter  int unsigned NUM_TESTS = 8,
    parameter  int unsigned TIMEOUT_W = 16,
    parameter  int unsigned CNT_W     = 8,
    localparam int unsigned ID_W      = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic [NUM_TESTS-1:0] enable_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 test_start_o,
    output logic [ID_W-1:0]      test_id_o,
    input  logic                 test_done_i,
    input  logic                 test_pass_i,
    output logic                 log_valid_o,
    input  logic                 log_ready_i,
    output logic [ID_W-1:0]      log_id_o,
    output logic [1:0]           log_result_o,
    output logic                 busy_o,
    output logic                 run_done_o,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o,
    output logic [CNT_W-1:0]     timeout_cnt_o,
    output logic [CNT_W-1:0]     skip_cnt_o
);

    localparam logic [31:0]     CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_TESTS - 1);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      idx_q, idx_d;
    logic [NUM_TESTS-1:0] mask_q, mask_d;
    logic [TIMEOUT_W-1:0] limit_q, limit_d;
    result_e              result_q, result_d;
    logic [CNT_W-1:0]     pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]     timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0]     skip_cnt_q, skip_cnt_d;
    logic                 busy_q, busy_d;
    logic                 test_start_q, test_start_d;
    logic                 log_valid_q, log_valid_d;
    logic                 run_done_q, run_done_d;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
    logic                 stop_q, stop_d;
`endif

    logic skip_c;
    logic wd_clr_c;
    logic wd_en_c;
    logic wd_expired_c;

    unit_test_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr_c),
        .en_i      (wd_en_c),
        .limit_i   (limit_q),
        .expired_c (wd_expired_c)
    );

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mask_d        = mask_q;
        limit_d       = limit_q;
        result_d      = result_q;
        pass_cnt_d    = pass_cnt_q;
        fail_cnt_d    = fail_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        skip_cnt_d    = skip_cnt_q;
        wd_clr_c      = 1'b0;
        wd_en_c       = 1'b0;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
        stop_d        = stop_q;
        skip_c        = !mask_q[idx_q] || stop_q;
`else
        skip_c        = !mask_q[idx_q];
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    mask_d        = enable_mask_i;
                    limit_d       = timeout_i;
                    pass_cnt_d    = '0;
                    fail_cnt_d    = '0;
                    timeout_cnt_d = '0;
                    skip_cnt_d    = '0;
                    idx_d         = '0;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
                    stop_d        = 1'b0;
`endif
                    state_d       = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (skip_c) begin
                    result_d = RES_SKIP;
                    state_d  = ST_LOG;
                end else begin
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                wd_clr_c = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en_c = 1'b1;
                if (test_done_i) begin
                    result_d = test_pass_i ? RES_PASS : RES_FAIL;
                    state_d  = ST_LOG;
                end else if (wd_expired_c) begin
                    result_d = RES_TIMEOUT;
                    state_d  = ST_LOG;
                end
            end
            ST_LOG: begin
                if (log_ready_i) begin
                    unique case (result_q)
                        RES_PASS:    pass_cnt_d    = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_MAX));
                        RES_FAIL:    fail_cnt_d    = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_MAX));
                        RES_TIMEOUT: timeout_cnt_d = CNT_W'(sat_inc(32'(timeout_cnt_q), CNT_MAX));
                        RES_SKIP:    skip_cnt_d    = CNT_W'(sat_inc(32'(skip_cnt_q), CNT_MAX));
                    endcase
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
                    if ((result_q == RES_FAIL) || (result_q == RES_TIMEOUT)) begin
                        stop_d = 1'b1;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ID_W'(1);
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        test_start_d = (state_d == ST_START);
        log_valid_d  = (state_d == ST_LOG);
        run_done_d   = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            mask_q        <= '0;
            limit_q       <= '0;
            result_q      <= RES_PASS;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            skip_cnt_q    <= '0;
            busy_q        <= 1'b0;
            test_start_q  <= 1'b0;
            log_valid_q   <= 1'b0;
            run_done_q    <= 1'b0;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
            stop_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            limit_q       <= limit_d;
            result_q      <= result_d;
            pass_cnt_q    <= pass_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            skip_cnt_q    <= skip_cnt_d;
            busy_q        <= busy_d;
            test_start_q  <= test_start_d;
            log_valid_q   <= log_valid_d;
            run_done_q    <= run_done_d;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
            stop_q        <= stop_d;
`endif
        end
    end

    assign test_start_o  = test_start_q;
    assign test_id_o     = idx_q;
    assign log_valid_o   = log_valid_q;
    assign log_id_o      = idx_q;
    assign log_result_o  = result_q;
    assign busy_o        = busy_q;
    assign run_done_o    = run_done_q;
    assign pass_cnt_o    = pass_cnt_q;
    assign fail_cnt_o    = fail_cnt_q;
    assign timeout_cnt_o = timeout_cnt_q;
    assign skip_cnt_o    = skip_cnt_q;

endmodule

// File: tb/tb_unit_test_run_ctrl.sv
// Directed bench for unit_test_run_ctrl with four slots and a scripted slot responder.
module tb_unit_test_run_ctrl;

    localparam int unsigned NT  = 4;
    localparam int unsigned TW  = 16;
    localparam int unsigned CW  = 8;
    localparam int unsigned IDW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run_i;
    logic [NT-1:0] enable_mask_i;
    logic [TW-1:0] timeout_i;
    logic          test_start_o;
    logic [IDW-1:0] test_id_o;
    logic          test_done_i;
    logic          test_pass_i;
    logic          log_valid_o;
    logic          log_ready_i;
    logic [IDW-1:0] log_id_o;
    logic [1:0]    log_result_o;
    logic          busy_o;
    logic          run_done_o;
    logic [CW-1:0] pass_cnt_o, fail_cnt_o, timeout_cnt_o, skip_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Slot responder script.
    bit resp_en   [NT];
    int resp_dly  [NT];
    bit resp_pass [NT];

    // Observations from the monitor.
    logic [IDW-1:0] rec_id  [16];
    logic [1:0]     rec_res [16];
    int             rec_n;
    int             start_seen [NT];
    int             done_seen;

    unit_test_run_ctrl #(
        .NUM_TESTS (NT),
        .TIMEOUT_W (TW),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run_i),
        .enable_mask_i (enable_mask_i),
        .timeout_i     (timeout_i),
        .test_start_o  (test_start_o),
        .test_id_o     (test_id_o),
        .test_done_i   (test_done_i),
        .test_pass_i   (test_pass_i),
        .log_valid_o   (log_valid_o),
        .log_ready_i   (log_ready_i),
        .log_id_o      (log_id_o),
        .log_result_o  (log_result_o),
        .busy_o        (busy_o),
        .run_done_o    (run_done_o),
        .pass_cnt_o    (pass_cnt_o),
        .fail_cnt_o    (fail_cnt_o),
        .timeout_cnt_o (timeout_cnt_o),
        .skip_cnt_o    (skip_cnt_o)
    );

    always #5 clk = ~clk;

    // Monitor: accepted log records, start pulses per slot, run_done pulses.
    initial begin
        rec_n     = 0;
        done_seen = 0;
        for (int i = 0; i < NT; i++) start_seen[i] = 0;
        forever begin
            @(negedge clk);
            if (log_valid_o && log_ready_i && rec_n < 16) begin
                rec_id[rec_n]  = log_id_o;
                rec_res[rec_n] = log_result_o;
                rec_n++;
            end
            if (test_start_o) start_seen[test_id_o]++;
            if (run_done_o) done_seen++;
        end
    end

    // Responder: answer a start pulse with done after resp_dly cycles.
    initial begin : responder
        int sid;
        test_done_i = 1'b0;
        test_pass_i = 1'b0;
        forever begin
            @(negedge clk);
            if (test_start_o) begin
                sid = int'(test_id_o);
                if (resp_en[sid]) begin
                    repeat (resp_dly[sid]) @(posedge clk);
                    #1;
                    test_pass_i = resp_pass[sid];
                    test_done_i = 1'b1;
                    @(posedge clk);
                    #1;
                    test_done_i = 1'b0;
                    test_pass_i = 1'b0;
                end
            end
        end
    end

    task automatic set_resp(input int dly, input bit pass);
        for (int i = 0; i < NT; i++) begin
            resp_en[i]   = 1'b1;
            resp_dly[i]  = dly;
            resp_pass[i] = pass;
        end
    endtask

    // Drive run_i for one cycle; returns #1 into the cycle after the run_i cycle.
    task automatic launch_run(input logic [NT-1:0] mask, input logic [TW-1:0] tmo);
        @(posedge clk); #1;
        rec_n     = 0;
        done_seen = 0;
        for (int i = 0; i < NT; i++) start_seen[i] = 0;
        enable_mask_i = mask;
        timeout_i     = tmo;
        run_i         = 1'b1;
        @(posedge clk); #1;
        run_i         = 1'b0;
        enable_mask_i = '0;
        timeout_i     = '0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            if (run_done_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({test_start_o, log_valid_o, busy_o, run_done_o} !== 4'b0) begin
            $display("FAIL reset_ctrl: start/valid/busy/done=%b required 0000",
                     {test_start_o, log_valid_o, busy_o, run_done_o});
            failures++;
        end
        checks++;
        if ({test_id_o, log_id_o, log_result_o} !== 6'b0) begin
            $display("FAIL reset_ids: id=%0d log_id=%0d res=%0d required 0", test_id_o, log_id_o, log_result_o);
            failures++;
        end
        checks++;
        if ({pass_cnt_o, fail_cnt_o, timeout_cnt_o, skip_cnt_o} !== 32'b0) begin
            $display("FAIL reset_cnts: p=%0d f=%0d t=%0d s=%0d required 0",
                     pass_cnt_o, fail_cnt_o, timeout_cnt_o, skip_cnt_o);
            failures++;
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            $display("FAIL reset_idle: busy=%b required 0", busy_o);
            failures++;
        end
    endtask

    task automatic test_all_pass();
        bit ok;
        logic [1:0] exp_res [NT];
        set_resp(5, 1'b1);
        exp_res = '{2'd0, 2'd0, 2'd0, 2'd0};
        launch_run(4'b1111, 16'd100);
        checks++;
        if (test_start_o !== 1'b0 || busy_o !== 1'b1) begin
            $display("FAIL latency_c1: start=%b busy=%b required start=0 busy=1", test_start_o, busy_o);
            failures++;
        end
        @(posedge clk); #1;
        checks++;
        if (test_start_o !== 1'b1 || test_id_o !== 2'd0) begin
            $display("FAIL latency_c2: start=%b id=%0d required start=1 id=0", test_start_o, test_id_o);
            failures++;
        end
        // A second run request while busy must be dropped.
        run_i = 1'b1;
        @(posedge clk); #1;
        run_i = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            $display("FAIL all_pass_done: run_done seen=0 required 1");
            failures++;
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_seen !== 1 || busy_o !== 1'b0) begin
            $display("FAIL all_pass_single_run: run_done pulses=%0d busy=%b required 1 and 0", done_seen, busy_o);
            failures++;
        end
        checks++;
        if (rec_n !== NT) begin
            $display("FAIL all_pass_nrec: records=%0d required %0d", rec_n, NT);
            failures++;
        end
        for (int i = 0; i < NT; i++) begin
            checks++;
            if (rec_n <= i || rec_id[i] !== 2'(i) || rec_res[i] !== exp_res[i]) begin
                $display("FAIL all_pass_rec%0d: id=%0d res=%0d required id=%0d res=%0d",
                         i, rec_id[i], rec_res[i], i, exp_res[i]);
                failures++;
            end
        end
        checks++;
        if (pass_cnt_o !== 8'd4 || fail_cnt_o !== 8'd0 || timeout_cnt_o !== 8'd0 || skip_cnt_o !== 8'd0) begin
            $display("FAIL all_pass_cnts: p=%0d f=%0d t=%0d s=%0d required 4 0 0 0",
                     pass_cnt_o, fail_cnt_o, timeout_cnt_o, skip_cnt_o);
            failures++;
        end
    endtask

    task automatic test_skip();
        bit ok;
        logic [1:0] exp_res [NT];
        set_resp(5, 1'b1);
        exp_res = '{2'd0, 2'd3, 2'd0, 2'd3};
        launch_run(4'b0101, 16'd100);
        wait_done(ok);
        checks++;
        if (!ok) begin
            $display("FAIL skip_done: run_done seen=0 required 1");
            failures++;
        end
        for (int i = 0; i < NT; i++) begin
            checks++;
            if (rec_n <= i || rec_id[i] !== 2'(i) || rec_res[i] !== exp_res[i]) begin
                $display("FAIL skip_rec%0d: id=%0d res=%0d required id=%0d res=%0d",
                         i, rec_id[i], rec_res[i], i, exp_res[i]);
                failures++;
            end
        end
        checks++;
        if (start_seen[1] !== 0 || start_seen[3] !== 0 || start_seen[0] !== 1 || start_seen[2] !== 1) begin
            $display("FAIL skip_starts: s0=%0d s1=%0d s2=%0d s3=%0d required 1 0 1 0",
                     start_seen[0], start_seen[1], start_seen[2], start_seen[3]);
            failures++;
        end
        checks++;
        if (pass_cnt_o !== 8'd2 || skip_cnt_o !== 8'd2) begin
            $display("FAIL skip_cnts: p=%0d s=%0d required 2 2", pass_cnt_o, skip_cnt_o);
            failures++;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [1:0] exp_res [NT];
        logic [CW-1:0] exp_pass, exp_skip;
        set_resp(5, 1'b1);
        resp_en[2] = 1'b0;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
        exp_res  = '{2'd0, 2'd0, 2'd2, 2'd3};
        exp_pass = 8'd2;
        exp_skip = 8'd1;
`else
        exp_res  = '{2'd0, 2'd0, 2'd2, 2'd0};
        exp_pass = 8'd3;
        exp_skip = 8'd0;
`endif
        launch_run(4'b1111, 16'd10);
        wait_done(ok);
        checks++;
        if (!ok) begin
            $display("FAIL timeout_done: run_done seen=0 required 1");
            failures++;
        end
        for (int i = 0; i < NT; i++) begin
            checks++;
            if (rec_n <= i || rec_id[i] !== 2'(i) || rec_res[i] !== exp_res[i]) begin
                $display("FAIL timeout_rec%0d: id=%0d res=%0d required id=%0d res=%0d",
                         i, rec_id[i], rec_res[i], i, exp_res[i]);
                failures++;
            end
        end
        checks++;
        if (timeout_cnt_o !== 8'd1 || pass_cnt_o !== exp_pass || skip_cnt_o !== exp_skip) begin
            $display("FAIL timeout_cnts: t=%0d p=%0d s=%0d required 1 %0d %0d",
                     timeout_cnt_o, pass_cnt_o, skip_cnt_o, exp_pass, exp_skip);
            failures++;
        end
        resp_en[2] = 1'b1;
    endtask

    task automatic test_log_stall();
        bit ok;
        bit seen;
        set_resp(5, 1'b0);
        log_ready_i = 1'b0;
        launch_run(4'b0001, 16'd100);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (log_valid_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL stall_valid: log_valid never rose required 1");
            failures++;
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (log_valid_o !== 1'b1 || log_id_o !== 2'd0 || log_result_o !== 2'd1 || fail_cnt_o !== 8'd0) begin
                $display("FAIL stall_hold%0d: valid=%b id=%0d res=%0d fcnt=%0d required 1 0 1 0",
                         c, log_valid_o, log_id_o, log_result_o, fail_cnt_o);
                failures++;
            end
        end
        @(posedge clk); #1;
        log_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (fail_cnt_o !== 8'd1) begin
            $display("FAIL stall_accept: fail_cnt=%0d required 1", fail_cnt_o);
            failures++;
        end
        wait_done(ok);
        checks++;
        if (!ok || fail_cnt_o !== 8'd1 || skip_cnt_o !== 8'd3 || rec_n !== 4) begin
            $display("FAIL stall_end: ok=%b f=%0d s=%0d recs=%0d required 1 1 3 4",
                     ok, fail_cnt_o, skip_cnt_o, rec_n);
            failures++;
        end
    endtask

    task automatic test_done_at_expiry();
        bit ok;
        logic [1:0] exp_res [NT];
        set_resp(10, 1'b1);
        resp_dly[1] = 11;
        exp_res = '{2'd0, 2'd2, 2'd3, 2'd3};
        launch_run(4'b0011, 16'd10);
        wait_done(ok);
        checks++;
        if (!ok) begin
            $display("FAIL expiry_done: run_done seen=0 required 1");
            failures++;
        end
        for (int i = 0; i < NT; i++) begin
            checks++;
            if (rec_n <= i || rec_id[i] !== 2'(i) || rec_res[i] !== exp_res[i]) begin
                $display("FAIL expiry_rec%0d: id=%0d res=%0d required id=%0d res=%0d",
                         i, rec_id[i], rec_res[i], i, exp_res[i]);
                failures++;
            end
        end
        checks++;
        if (pass_cnt_o !== 8'd1 || timeout_cnt_o !== 8'd1 || skip_cnt_o !== 8'd2) begin
            $display("FAIL expiry_cnts: p=%0d t=%0d s=%0d required 1 1 2",
                     pass_cnt_o, timeout_cnt_o, skip_cnt_o);
            failures++;
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        set_resp(5, 1'b1);
        launch_run(4'b1111, 16'd100);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (test_start_o) seen = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {test_start_o, log_valid_o, busy_o, run_done_o} !== 4'b0 ||
            {test_id_o, log_id_o, log_result_o} !== 6'b0) begin
            $display("FAIL midrun_reset: seen=%b ctrl=%b id=%0d log_id=%0d res=%0d required 1 0000 0 0 0",
                     seen, {test_start_o, log_valid_o, busy_o, run_done_o}, test_id_o, log_id_o, log_result_o);
            failures++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_seen !== 0 || busy_o !== 1'b0 || pass_cnt_o !== 8'd0 || rec_n !== 0) begin
            $display("FAIL midrun_after: run_done=%0d busy=%b p=%0d recs=%0d required 0 0 0 0",
                     done_seen, busy_o, pass_cnt_o, rec_n);
            failures++;
        end
    endtask

    task automatic test_stop_on_fail();
        bit ok;
        logic [1:0] exp_res [NT];
        int exp_starts;
        logic [CW-1:0] exp_skip, exp_pass;
        set_resp(5, 1'b1);
        resp_pass[1] = 1'b0;
`ifdef UNIT_TEST_STOP_ON_FAIL_EN
        exp_res    = '{2'd0, 2'd1, 2'd3, 2'd3};
        exp_starts = 2;
        exp_skip   = 8'd2;
        exp_pass   = 8'd1;
`else
        exp_res    = '{2'd0, 2'd1, 2'd0, 2'd0};
        exp_starts = 4;
        exp_skip   = 8'd0;
        exp_pass   = 8'd3;
`endif
        launch_run(4'b1111, 16'd100);
        wait_done(ok);
        checks++;
        if (!ok) begin
            $display("FAIL stop_done: run_done seen=0 required 1");
            failures++;
        end
        for (int i = 0; i < NT; i++) begin
            checks++;
            if (rec_n <= i || rec_id[i] !== 2'(i) || rec_res[i] !== exp_res[i]) begin
                $display("FAIL stop_rec%0d: id=%0d res=%0d required id=%0d res=%0d",
                         i, rec_id[i], rec_res[i], i, exp_res[i]);
                failures++;
            end
        end
        checks++;
        if ((start_seen[0] + start_seen[1] + start_seen[2] + start_seen[3]) !== exp_starts) begin
            $display("FAIL stop_starts: starts=%0d required %0d",
                     start_seen[0] + start_seen[1] + start_seen[2] + start_seen[3], exp_starts);
            failures++;
        end
        checks++;
        if (fail_cnt_o !== 8'd1 || skip_cnt_o !== exp_skip || pass_cnt_o !== exp_pass) begin
            $display("FAIL stop_cnts: f=%0d s=%0d p=%0d required 1 %0d %0d",
                     fail_cnt_o, skip_cnt_o, pass_cnt_o, exp_skip, exp_pass);
            failures++;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (fail_cnt_o !== 8'd1 || busy_o !== 1'b0) begin
            $display("FAIL stop_hold: f=%0d busy=%b required 1 0", fail_cnt_o, busy_o);
            failures++;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        run_i         = 1'b0;
        enable_mask_i = '0;
        timeout_i     = '0;
        log_ready_i   = 1'b1;
        set_resp(5, 1'b1);
        test_reset();
        test_all_pass();
        test_skip();
        test_timeout();
        test_log_stall();
        test_done_at_expiry();
        test_reset_mid_run();
        test_stop_on_fail();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
